line_buffer: RTL and testbench
==============================

Name: line_buffer

Overview:
- Transmitter feeding the kernel shift-register array.
- Accepts one raster-order pixel stream and stores the previous BLOCK_HEIGHT-1 image lines.
- Emits one vertical column of BLOCK_HEIGHT pixels per accepted input pixel, presented on per-row valid/ready lanes that match the kernel's per-row inputs.
- Sits between the pixel source (gradient/grayscale stage) and the kernel.

Parameters:
- DATA_WIDTH, 8, bits per pixel.
- BLOCK_HEIGHT, 3, rows per output column (kernel height); >= 2.
- IMAGE_WIDTH, 640, pixels per line.
- IMAGE_HEIGHT, 480, lines per frame.
- OUTPUT_WIDTH, DATA_WIDTH*BLOCK_HEIGHT, width of out_pixels.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- in_pixel  input  DATA_WIDTH  incoming raster pixel.
- in_valid  input  1  in_pixel valid.
- in_ready  output  1  block accepts in_pixel this cycle.
- out_pixels  output  OUTPUT_WIDTH  column; slice i*DATA_WIDTH +: DATA_WIDTH is image row r-(BLOCK_HEIGHT-1-i); i=0 is the oldest (top) row, i=BLOCK_HEIGHT-1 is the current row.
- out_valid  output  BLOCK_HEIGHT  per-row lane valid.
- out_ready  input  BLOCK_HEIGHT  per-row lane ready from the kernel.

Behaviour:
- Reset (async, rst=0):
  - out_valid=0, out_pixels=0, in_ready=0.
  - col_cnt=0, row_cnt=0, primed=0.
  - Line storage contents are don't-care; no output is produced until they are rewritten.
- Storage: BLOCK_HEIGHT-1 lines of IMAGE_WIDTH x DATA_WIDTH each, indexed by col_cnt, read combinationally at col_cnt.
- Input accept: acc = in_valid & in_ready.
- in_ready = rst & ~|(out_valid & ~out_ready).
  - Asserted when no lane holds an unconsumed column, or every pending lane completes this cycle.
- On acc, at column c = col_cnt:
  - Line k takes line k+1 at column c, for k=0..BLOCK_HEIGHT-3.
  - Line BLOCK_HEIGHT-2 takes in_pixel at column c.
  - If primed, the output register loads {in_pixel, line BLOCK_HEIGHT-2[c], ..., line 0[c]} (pre-update values, MSB slice = in_pixel) and out_valid is set to all ones next cycle.
  - If not primed, the output register and out_valid are unchanged by the load; lanes still drain per the lane-handshake rule.
- Latency: pixel accepted in cycle t appears on out_pixels with out_valid set in cycle t+1.
- Lane handshake: lane i completes when out_valid[i] & out_ready[i]; that bit clears next cycle unless a new load occurs.
  - Lanes drain independently; out_pixels is held stable while any out_valid bit is set.
  - A load and the final lane completion in the same cycle are allowed (back-to-back throughput of 1 column/cycle).
  - out_valid never depends combinationally on out_ready.
- Counters:
  - col_cnt increments on acc and wraps IMAGE_WIDTH-1 -> 0.
  - At wrap, row_cnt increments and wraps IMAGE_HEIGHT-1 -> 0.
- Priming:
  - primed is set when row_cnt reaches BLOCK_HEIGHT-1 at a line wrap.
  - primed is cleared when row_cnt wraps to 0 (end of frame).
  - The first BLOCK_HEIGHT-1 lines of each frame produce no output.
  - Output count per frame = IMAGE_WIDTH*(IMAGE_HEIGHT-BLOCK_HEIGHT+1).
- Frame boundary: the last column of frame N may still be draining while frame N+1 priming pixels arrive; in_ready gating alone governs this, and no data corruption is permitted.
- in_valid without in_ready: no state change. Source must hold in_pixel stable.
- Reset mid-frame: all counters, primed and out_valid clear immediately (async); the next frame restarts priming.

Test Plan:
- Common setup: IMAGE_WIDTH=4, IMAGE_HEIGHT=4, BLOCK_HEIGHT=3, DATA_WIDTH=8; pixel value = row*16+col.
- Priming: stream rows 0-1 with out_ready=111 -> out_valid stays 000 for all 8 pixels; in_ready=1 throughout.
- First column: feed pixel 0x20 (row2,col0) -> next cycle out_valid=111, out_pixels={0x20,0x10,0x00}; total of 8 valid columns for the frame, last = {0x33,0x23,0x13}.
- Independent lanes: hold out_ready=001, then 010, then 100 -> out_valid steps 111->110->100->000; in_ready=0 until the cycle out_ready[2]=1, data stable throughout.
- Back-to-back: out_ready=111 and in_valid continuous -> one column per cycle, no bubbles, no duplicate or dropped columns (scoreboard vs. reference model).
- Frame wrap: two frames back-to-back, second frame values +0x80 -> frame 2 first output {0xA0,0x90,0x80}; no column mixing frame 1 rows.
- Reset mid-frame: assert rst=0 with out_valid=111 during row 2 -> out_valid=000 and in_ready=0 asynchronously; after release, rows 0-1 re-prime with no output.

Source files
------------

// File: rtl/line_buffer.sv
// line_buffer: keeps the previous BLOCK_HEIGHT-1 lines of a raster pixel stream and
// emits one vertical column per accepted pixel on independent per-row valid/ready lanes.
module line_buffer #(
    parameter int DATA_WIDTH   = 8,
    parameter int BLOCK_HEIGHT = 3,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int OUTPUT_WIDTH = DATA_WIDTH * BLOCK_HEIGHT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_pixel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [OUTPUT_WIDTH-1:0] out_pixels,
    output logic [BLOCK_HEIGHT-1:0] out_valid,
    input  logic [BLOCK_HEIGHT-1:0] out_ready
);
    localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMAGE_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_PRIME = RW'(BLOCK_HEIGHT - 1);

    logic [DATA_WIDTH-1:0]   r_lines [BLOCK_HEIGHT-1][IMAGE_WIDTH];
    logic [CW-1:0]           r_col;
    logic [RW-1:0]           r_row;
    logic                    r_primed;
    logic [OUTPUT_WIDTH-1:0] r_out;
    logic [BLOCK_HEIGHT-1:0] r_valid;
    logic                    w_acc;
    logic                    w_load;
    logic                    w_col_wrap;
    logic [RW-1:0]           w_row_next;
    logic [OUTPUT_WIDTH-1:0] w_column;

    // A new column may enter once every lane still holding data finishes this cycle.
    assign in_ready   = rst & ~|(r_valid & ~out_ready);
    assign w_acc      = in_valid & in_ready;
    assign w_load     = w_acc & r_primed;
    assign w_col_wrap = r_col == COL_LAST;
    assign w_row_next = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
    assign out_pixels = r_out;
    assign out_valid  = r_valid;

    always_comb begin
        w_column = '0;
        for (int i = 0; i < BLOCK_HEIGHT - 1; i++)
            w_column[i*DATA_WIDTH +: DATA_WIDTH] = r_lines[i][r_col];
        w_column[(BLOCK_HEIGHT-1)*DATA_WIDTH +: DATA_WIDTH] = in_pixel;
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            for (int k = 0; k < BLOCK_HEIGHT - 2; k++)
                r_lines[k][r_col] <= r_lines[k+1][r_col];
            r_lines[BLOCK_HEIGHT-2][r_col] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col    <= '0;
            r_row    <= '0;
            r_primed <= 1'b0;
            r_out    <= '0;
            r_valid  <= '0;
        end else begin
            r_valid <= w_load ? '1 : r_valid & ~out_ready;
            if (w_load)
                r_out <= w_column;
            if (w_acc) begin
                r_col <= w_col_wrap ? '0 : r_col + 1'b1;
                if (w_col_wrap) begin
                    r_row <= w_row_next;
                    if (w_row_next == '0)
                        r_primed <= 1'b0;
                    else if (w_row_next == ROW_PRIME)
                        r_primed <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_line_buffer.sv
// tb_line_buffer: directed stimulus with a queue scoreboard; a negedge monitor pops an
// expected column each time the DUT presents a fresh one and checks it is held while draining.
module tb_line_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_pixel = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] out_pixels;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready = 3'b111;

    int          checks = 0;
    int          failures = 0;
    int          stalls = 0;
    logic [23:0] sb[$];
    logic        pending = 1'b0;
    logic [23:0] held = '0;

    line_buffer #(
        .DATA_WIDTH(8), .BLOCK_HEIGHT(3), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4)
    ) dut (
        .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid),
        .in_ready(in_ready), .out_pixels(out_pixels), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] px(input logic [7:0] base, input int r, input int c);
        return base + 8'(r * 16 + c);
    endfunction

    task automatic send(input int r, input int c, input logic [7:0] base);
        int n = 0;
        in_pixel = px(base, r, c);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            stalls++;
            @(negedge clk);
        end
        if (!in_ready)
            chk("accept_timeout", {31'b0, in_ready}, 1);
        else if (r >= 2)
            sb.push_back({px(base, r, c), px(base, r - 1, c), px(base, r - 2, c)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic prime(input logic [7:0] base);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) begin
                send(r, c, base);
                chk("prime_valid", {29'b0, out_valid}, 0);
                chk("prime_in_ready", {31'b0, in_ready}, 1);
            end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            pending = 1'b0;
        end else begin
            if (out_valid != 3'b000) begin
                if (!pending) begin
                    if (sb.size() == 0) begin
                        chk("extra_column", sb.size(), 1);
                    end else begin
                        chk("column", {8'b0, out_pixels}, {8'b0, sb.pop_front()});
                        chk("column_valid", {29'b0, out_valid}, 3'b111);
                    end
                end else begin
                    chk("column_hold", {8'b0, out_pixels}, {8'b0, held});
                end
            end
            pending = |(out_valid & ~out_ready);
            held = out_pixels;
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_valid", {29'b0, out_valid}, 0);
        chk("reset_pixels", {8'b0, out_pixels}, 0);
        chk("reset_in_ready", {31'b0, in_ready}, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        prime(8'h00);

        // first column, drained one lane at a time
        out_ready = 3'b001;
        send(2, 0, 8'h00);
        @(negedge clk);
        chk("lane_step0_valid", {29'b0, out_valid}, 3'b111);
        chk("lane_step0_ready", {31'b0, in_ready}, 0);
        @(posedge clk);
        #1 out_ready = 3'b010;
        @(negedge clk);
        chk("lane_step1_valid", {29'b0, out_valid}, 3'b110);
        chk("lane_step1_ready", {31'b0, in_ready}, 0);
        @(posedge clk);
        #1 out_ready = 3'b100;
        @(negedge clk);
        chk("lane_step2_valid", {29'b0, out_valid}, 3'b100);
        chk("lane_step2_ready", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1 out_ready = 3'b111;
        @(negedge clk);
        chk("lane_drained", {29'b0, out_valid}, 0);
        @(posedge clk);
        #1;

        // back-to-back rest of frame 1 straight into frame 2
        stalls = 0;
        for (int c = 1; c < 4; c++) send(2, c, 8'h00);
        for (int c = 0; c < 4; c++) send(3, c, 8'h00);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) send(r, c, 8'h80);
        chk("b2b_stalls", stalls, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("frame_sb_empty", sb.size(), 0);

        // reset in the middle of row 2 with a column stuck on the lanes
        prime(8'h40);
        out_ready = 3'b000;
        send(2, 0, 8'h40);
        @(posedge clk);
        #1;
        chk("pre_reset_valid", {29'b0, out_valid}, 3'b111);
        rst = 1'b0;
        #1;
        chk("async_reset_valid", {29'b0, out_valid}, 0);
        chk("async_reset_in_ready", {31'b0, in_ready}, 0);
        chk("async_reset_pixels", {8'b0, out_pixels}, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 3'b111;
        prime(8'h10);
        send(2, 0, 8'h10);
        send(2, 1, 8'h10);
        repeat (3) @(posedge clk);
        #1;
        chk("final_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
